// File: rtl/serial_negator.sv
// Serial LSB-first word processor: pass, two's-complement negate, or ones' complement.
//
// The negate path uses the classic serial rule: copy bits up to and including the first 1,
// then invert every bit after it. Each result bit is registered and appears one cycle after
// its input is accepted. A parallel copy of each completed word, plus an overflow flag for
// negating the most-negative value, is held until the next word completes.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   sync_clr   synchronous realign/abort; discards the partial word, wins over in_valid
//   in_valid   in_bit is valid this cycle
//   in_bit     serial data, LSB first
//   mode       00 pass, 01 negate, 10 ones' complement, 11 pass (latched at bit 0 of a word)
//   out_valid  out_bit is valid this cycle
//   out_bit    serial result bit, LSB first
//   word_done  one-cycle pulse alongside the last result bit of a word
//   word_out   last completed result word, bit 0 = first result bit
//   overflow   last completed word was a negate of 2^(WIDTH-1)
//   bit_idx    index of the next input bit expected
module serial_negator #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_clr,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic             out_bit,
  output logic             word_done,
  output logic [WIDTH-1:0] word_out,
  output logic             overflow,
  output logic [IdxW-1:0]  bit_idx
);

  typedef enum logic [0:0] {StSeek, StInvert} state_e;

  localparam logic [1:0] ModeNeg = 2'b01;
  localparam logic [1:0] ModeOnes = 2'b10;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             zeros_q, zeros_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             word_done_q, word_done_d;

  logic             accept;
  logic             first;
  logic             last;
  logic [1:0]       eff_mode;
  logic             res_bit;

  assign accept   = in_valid & ~sync_clr;
  assign first    = (bit_idx_q == '0);
  assign last     = (bit_idx_q == IdxW'(WIDTH - 1));
  // Bit 0 uses the live mode input since that is the cycle in which it gets latched.
  assign eff_mode = first ? mode : mode_q;

  always_comb begin
    res_bit = in_bit;
    case (eff_mode)
      ModeNeg:  res_bit = (state_q == StSeek) ? in_bit : ~in_bit;
      ModeOnes: res_bit = ~in_bit;
      default:  res_bit = in_bit;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    mode_d      = mode_q;
    shreg_d     = shreg_q;
    word_out_d  = word_out_q;
    zeros_d     = zeros_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    word_done_d = 1'b0;

    if (sync_clr) begin
      state_d   = StSeek;
      bit_idx_d = '0;
      shreg_d   = '0;
      zeros_d   = 1'b0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      out_bit_d   = res_bit;
      if (first) begin
        mode_d = mode;
      end
      // zeros_q tracks whether every bit before the current one was 0.
      zeros_d = first ? ~in_bit : (zeros_q & ~in_bit);

      if (last) begin
        state_d     = StSeek;
        bit_idx_d   = '0;
        shreg_d     = '0;
        word_done_d = 1'b1;
        word_out_d  = {res_bit, shreg_q[WIDTH-1:1]};
        overflow_d  = (eff_mode == ModeNeg) && zeros_q && in_bit;
      end else begin
        bit_idx_d = bit_idx_q + IdxW'(1);
        shreg_d   = {res_bit, shreg_q[WIDTH-1:1]};
        if (eff_mode == ModeNeg && (state_q == StInvert || in_bit)) begin
          state_d = StInvert;
        end else begin
          state_d = StSeek;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StSeek;
      bit_idx_q   <= '0;
      mode_q      <= 2'b00;
      shreg_q     <= '0;
      word_out_q  <= '0;
      zeros_q     <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      mode_q      <= mode_d;
      shreg_q     <= shreg_d;
      word_out_q  <= word_out_d;
      zeros_q     <= zeros_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      word_done_q <= word_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign word_done = word_done_q;
  assign word_out  = word_out_q;
  assign overflow  = overflow_q;
  assign bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_serial_negator.sv
// Directed self-checking bench for serial_negator at WIDTH=8.
module tb_serial_negator;

  localparam int unsigned WIDTH = 8;

  logic       clk;
  logic       reset;
  logic       sync_clr;
  logic       in_valid;
  logic       in_bit;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_bit;
  logic       word_done;
  logic [7:0] word_out;
  logic       overflow;
  logic [2:0] bit_idx;

  int checks = 0;
  int errors = 0;

  serial_negator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .mode      (mode),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .word_done (word_done),
    .word_out  (word_out),
    .overflow  (overflow),
    .bit_idx   (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_word, input logic exp_ovf);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " out_bit"}, {31'd0, out_bit}, 32'd0);
    check({tag, " word_done"}, {31'd0, word_done}, 32'd0);
    check({tag, " word_out"}, {24'd0, word_out}, {24'd0, exp_word});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, " bit_idx"}, {29'd0, bit_idx}, 32'd0);
  endtask

  // Drive one accepted bit, then sample #1 after the edge that registers its result.
  task automatic send_bit(input string tag, input logic b, input logic [1:0] m,
                          input logic exp_bit, input logic exp_done, input int exp_idx);
    in_valid = 1'b1;
    in_bit   = b;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " out_bit"}, {31'd0, out_bit}, {31'd0, exp_bit});
    check({tag, " word_done"}, {31'd0, word_done}, {31'd0, exp_done});
    check({tag, " bit_idx"}, {29'd0, bit_idx}, exp_idx);
  endtask

  // Whole word; mode switches from m to m2 after bit sw; gaps>0 inserts 1-3 idle cycles.
  task automatic send_word(input string tag, input logic [7:0] w, input logic [1:0] m,
                           input logic [1:0] m2, input int sw, input bit gaps,
                           input logic [7:0] exp_word, input logic exp_ovf);
    for (int i = 0; i < 8; i++) begin
      send_bit(tag, w[i], (i > sw) ? m2 : m, exp_word[i], (i == 7), (i + 1) % 8);
      if (gaps && i < 7) begin
        for (int g = 0; g <= (i % 3); g++) begin
          in_bit = ~in_bit;
          @(posedge clk);
          #1;
          check({tag, " gap out_valid"}, {31'd0, out_valid}, 32'd0);
          check({tag, " gap word_done"}, {31'd0, word_done}, 32'd0);
        end
      end
    end
    check({tag, " word_out"}, {24'd0, word_out}, {24'd0, exp_word});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    // One idle cycle: pulse ends, word_out holds.
    @(posedge clk);
    #1;
    check({tag, " done pulse end"}, {31'd0, word_done}, 32'd0);
    check({tag, " word_out hold"}, {24'd0, word_out}, {24'd0, exp_word});
  endtask

  initial begin
    reset    = 1'b1;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    mode     = 2'b00;
    #1;
    check_idle("during reset", 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_idle("after reset", 8'h00, 1'b0);

    // -0x0C = 0xF4
    send_word("neg 0C", 8'h0C, 2'b01, 2'b01, 7, 1'b0, 8'hF4, 1'b0);
    // Most-negative value, then back to normal
    send_word("neg 80", 8'h80, 2'b01, 2'b01, 7, 1'b0, 8'h80, 1'b1);
    send_word("neg 01", 8'h01, 2'b01, 2'b01, 7, 1'b0, 8'hFF, 1'b0);
    send_word("neg 00", 8'h00, 2'b01, 2'b01, 7, 1'b0, 8'h00, 1'b0);
    send_word("neg 7F", 8'h7F, 2'b01, 2'b01, 7, 1'b0, 8'h81, 1'b0);
    send_word("ones 0C", 8'h0C, 2'b10, 2'b10, 7, 1'b0, 8'hF3, 1'b0);
    send_word("ones 80", 8'h80, 2'b10, 2'b10, 7, 1'b0, 8'h7F, 1'b0);
    send_word("pass A5", 8'hA5, 2'b00, 2'b00, 7, 1'b0, 8'hA5, 1'b0);
    send_word("mode11 80", 8'h80, 2'b11, 2'b11, 7, 1'b0, 8'h80, 1'b0);

    // Gapped input gives the same result
    send_word("neg 0C gaps", 8'h0C, 2'b01, 2'b01, 7, 1'b1, 8'hF4, 1'b0);

    // Mode change mid-word is ignored; next word uses the new mode
    send_word("mode switch", 8'h0C, 2'b01, 2'b00, 2, 1'b0, 8'hF4, 1'b0);
    send_word("after switch", 8'h0C, 2'b00, 2'b00, 7, 1'b0, 8'h0C, 1'b0);

    // Partial word then async reset
    send_bit("partA b0", 1'b0, 2'b01, 1'b0, 1'b0, 1);
    send_bit("partA b1", 1'b0, 2'b01, 1'b0, 1'b0, 2);
    send_bit("partA b2", 1'b1, 2'b01, 1'b1, 1'b0, 3);
    #2;
    reset = 1'b1;
    #1;
    check_idle("async reset", 8'h00, 1'b0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_idle("post reset", 8'h00, 1'b0);
    send_word("neg 03 after rst", 8'h03, 2'b01, 2'b01, 7, 1'b0, 8'hFD, 1'b0);

    // Partial word then sync_clr (with in_valid high); word_out/overflow hold
    send_word("neg 80 pre clr", 8'h80, 2'b01, 2'b01, 7, 1'b0, 8'h80, 1'b1);
    send_bit("partB b0", 1'b0, 2'b01, 1'b0, 1'b0, 1);
    send_bit("partB b1", 1'b0, 2'b01, 1'b0, 1'b0, 2);
    send_bit("partB b2", 1'b1, 2'b01, 1'b1, 1'b0, 3);
    sync_clr = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    check_idle("sync_clr", 8'h80, 1'b1);
    send_word("neg 03 after clr", 8'h03, 2'b01, 2'b01, 7, 1'b0, 8'hFD, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
